// File: rtl/msg_seq_ctrl.sv
// Message sequencer: latches a word and bit period on start, then walks the
// datapath through the word one bit at a time, single-shot or repeating.
module msg_seq_ctrl #(
  parameter int MSG_W = 5,
  parameter int DIV_W = 10,
  parameter int CNT_W = 8,
  localparam int IW   = (MSG_W > 1) ? $clog2(MSG_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             start,
  input  logic             mode,
  input  logic             sel,
  input  logic [MSG_W-1:0] msg,
  input  logic [DIV_W-1:0] SW,
  output logic             busy,
  output logic             done,
  output logic             shift_en,
  output logic             bit_out,
  output logic [IW-1:0]    bit_idx,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [IW-1:0] LAST = IW'(MSG_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, nxt;
  logic [MSG_W-1:0] lmsg;
  logic             lmode, lsel;
  logic [DIV_W-1:0] ldiv, div_cnt, sw_eff;
  logic [IW-1:0]    pos;
  logic             frame_end;

  // A zero period would stall the divider; run it as one cycle per bit.
  assign sw_eff    = (SW == '0) ? DIV_W'(1) : SW;
  assign frame_end = (div_cnt == '0) && (bit_idx == LAST);
  assign pos       = lsel ? bit_idx : (LAST - bit_idx);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state and Moore outputs, all decoded from registered state.
  always_comb begin
    nxt      = state;
    busy     = 1'b0;
    done     = 1'b0;
    shift_en = 1'b0;
    bit_out  = 1'b0;
    case (state)
      S_IDLE: if (start) nxt = S_RUN;
      S_RUN: begin
        busy     = 1'b1;
        shift_en = (div_cnt == '0);
        bit_out  = lmsg[pos];
        if (frame_end && !lmode) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    // Abort beats everything, including a same-cycle start.
    if (init) nxt = S_IDLE;
  end

  // Latches, bit divider, bit index and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lmsg      <= '0;
      lmode     <= 1'b0;
      lsel      <= 1'b0;
      ldiv      <= '0;
      div_cnt   <= '0;
      bit_idx   <= '0;
      frame_cnt <= '0;
    end else if (init) begin
      div_cnt   <= '0;
      bit_idx   <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          lmsg    <= msg;
          lmode   <= mode;
          lsel    <= sel;
          ldiv    <= sw_eff;
          div_cnt <= sw_eff - DIV_W'(1);
          bit_idx <= '0;
        end
        S_RUN: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            // Reload here too so continuous mode rolls into the next frame gap-free.
            div_cnt <= ldiv - DIV_W'(1);
            if (bit_idx == LAST) begin
              bit_idx   <= '0;
              frame_cnt <= frame_cnt + CNT_W'(1);
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_seq_ctrl.sv
// Bench for msg_seq_ctrl: expected per-cycle outputs are queued when stimulus
// is applied and popped one per clock as the DUT advances.
module tb_msg_seq_ctrl;

  localparam int MSG_W = 5;
  localparam int DIV_W = 10;
  localparam int CNT_W = 8;
  localparam int IW    = 3;

  logic             clk = 1'b0;
  logic             rst, init, start, mode, sel;
  logic [MSG_W-1:0] msg;
  logic [DIV_W-1:0] SW;
  logic             busy, done, shift_en, bit_out;
  logic [IW-1:0]    bit_idx;
  logic [CNT_W-1:0] frame_cnt;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             shift_en;
    logic             bit_out;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] fc;
  } obs_t;

  obs_t  expq[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  string scen   = "reset";
  int    fc     = 0;

  msg_seq_ctrl #(.MSG_W(MSG_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .init(init), .start(start), .mode(mode), .sel(sel),
    .msg(msg), .SW(SW), .busy(busy), .done(done), .shift_en(shift_en),
    .bit_out(bit_out), .bit_idx(bit_idx), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input obs_t obs, input obs_t exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got busy=%b done=%b sh=%b bit=%b idx=%0d fc=%0d, want busy=%b done=%b sh=%b bit=%b idx=%0d fc=%0d",
                  tag, obs.busy, obs.done, obs.shift_en, obs.bit_out, obs.idx, obs.fc,
                  exp.busy, exp.done, exp.shift_en, exp.bit_out, exp.idx, exp.fc);
  endtask

  task automatic push(input logic b, d, s, o, input int idx, input int f);
    obs_t e;
    e.busy = b; e.done = d; e.shift_en = s; e.bit_out = o;
    e.idx = IW'(idx); e.fc = CNT_W'(f);
    expq.push_back(e);
  endtask

  task automatic push_idle(input int f);
    push(0, 0, 0, 0, 0, f);
  endtask

  // One full frame of RUN cycles; the count bumps on the edge after the last.
  task automatic push_frame(input logic [MSG_W-1:0] m, input logic s, input int div, input int f);
    for (int i = 0; i < MSG_W; i++)
      for (int k = 0; k < div; k++)
        push(1, 0, k == div - 1, s ? m[i] : m[MSG_W-1-i], i, f);
  endtask

  // Advance one clock, then compare the settled outputs against the queue head.
  task automatic tick();
    obs_t o;
    @(posedge clk);
    #1;
    o = {busy, done, shift_en, bit_out, bit_idx, frame_cnt};
    if (expq.size() > 0) chk(scen, o, expq.pop_front());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1; init = 0; start = 1;
    mode = 1'($urandom); sel = 1'($urandom);
    msg = MSG_W'($urandom); SW = DIV_W'($urandom);

    // Reset with start held: nothing must launch.
    push_idle(0); push_idle(0);
    ticks(2);
    rst = 0; start = 0;
    push_idle(0);
    tick();

    // Single-shot MSB-first, with mid-run input churn that must be ignored.
    scen = "single_msb";
    msg = 5'b10101; SW = 3; sel = 0; mode = 0; start = 1;
    push_frame(5'b10101, 0, 3, 0);
    push(0, 1, 0, 0, 0, 1);
    push_idle(1);
    tick();
    start = 0;
    ticks(4);
    scen = "latch_hold";
    msg = 5'b01010; SW = 7; sel = 1; mode = 1; start = 1;
    tick();
    start = 0;
    ticks(11);
    ticks(2);
    fc = 1;

    // LSB-first with a zero period: one bit per cycle.
    scen = "lsb_sw0";
    msg = 5'b00011; SW = 0; sel = 1; mode = 0; start = 1;
    push_frame(5'b00011, 1, 1, fc);
    push(0, 1, 0, 0, 0, fc + 1);
    push_idle(fc + 1);
    tick();
    start = 0;
    ticks(6);
    fc++;

    // Clear the frame count from IDLE, then run continuously and abort.
    scen = "init_idle";
    init = 1;
    push_idle(0);
    tick();
    init = 0;
    scen = "continuous";
    msg = 5'b10000; SW = 2; sel = 0; mode = 1; start = 1;
    for (int f = 0; f < 3; f++) push_frame(5'b10000, 0, 2, f);
    push(1, 0, 0, 1, 0, 3);
    tick();
    start = 0;
    ticks(30);
    scen = "abort";
    init = 1;
    push_idle(0);
    tick();
    init = 0;
    push_idle(0); push_idle(0);
    ticks(2);

    // Reset while partway through a frame.
    scen = "rst_mid";
    msg = 5'b10101; SW = 1; sel = 0; mode = 0; start = 1;
    push(1, 0, 1, 1, 0, 0);
    push(1, 0, 1, 0, 1, 0);
    push(1, 0, 1, 1, 2, 0);
    tick();
    start = 0;
    ticks(2);
    rst = 1;
    push_idle(0);
    tick();
    rst = 0;
    push_idle(0);
    tick();

    // init and start together: init wins.
    scen = "init_start";
    init = 1; start = 1; mode = 0;
    push_idle(0);
    tick();
    init = 0; start = 0;
    push_idle(0); push_idle(0);
    ticks(2);

    // Continuous with a one-cycle period long enough to wrap the frame count.
    scen = "wrap";
    msg = 5'b11001; SW = 1; sel = 1; mode = 1; start = 1;
    push_frame(5'b11001, 1, 1, 0);
    tick();
    start = 0;
    ticks(4);
    for (int f = 1; f <= 257; f++) begin
      push_frame(5'b11001, 1, 1, f & 8'hff);
      ticks(5);
    end
    init = 1;
    push_idle(0);
    tick();
    init = 0;

    if (expq.size() != 0) begin
      n_chk++;
      $display("FAIL leftover: %0d expected cycles never compared, want 0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
